// File: rtl/vga_sync_rx.sv
// rtl/vga_sync_rx.sv - VGA Pmod receiver: sync recovery, mode check, lock FSM, pixel output
module vga_sync_rx #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_OFFSET    = 144,
  parameter int V_OFFSET    = 35,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter bit SYNC_NEG    = 1'b1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vga_in,
  output logic       locked,
  output logic       pix_valid,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [5:0] rgb,
  output logic       frame_start,
  output logic [7:0] frame_count,
  output logic       err_line,
  output logic       err_frame
);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_e;

  localparam logic [9:0]  HT_M1   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  VT_M1   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_OFF10 = 10'(H_OFFSET);
  localparam logic [9:0]  V_OFF10 = 10'(V_OFFSET);
  localparam logic [10:0] H_LO    = 11'(H_OFFSET);
  localparam logic [10:0] H_HI    = 11'(H_OFFSET + H_ACTIVE);
  localparam logic [10:0] V_LO    = 11'(V_OFFSET);
  localparam logic [10:0] V_HI    = 11'(V_OFFSET + V_ACTIVE);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

  logic [7:0] s_q;
  logic       s_vld_q, hs_d_q, v_prev_q;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  state_e     state_q, state_d;
  logic [3:0] good_q, good_d, good_inc;
  logic       frame_start_q, err_line_q, err_frame_q;
  logic [7:0] frame_count_q, frame_count_d;
  logic       pix_valid_q, pix_valid_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [5:0] rgb_q, rgb_d;

  logic hs, vs, h_edge, fstart, timeout, line_bad, frame_bad, v_prev_d;
  logic h_in, v_in, in_check;

  // Reset value of s decodes as asserted syncs; s_vld_q masks that one bogus sample.
  assign hs       = s_q[7] ^ SYNC_NEG;
  assign vs       = s_q[3] ^ SYNC_NEG;
  assign h_edge   = s_vld_q & hs & ~hs_d_q;
  assign fstart   = h_edge & vs & ~v_prev_q;
  assign v_prev_d = h_edge ? vs : v_prev_q;

  assign timeout   = ~h_edge & (hcnt_q == 10'h3FE);
  assign line_bad  = (h_edge & (hcnt_q != HT_M1)) | timeout;
  assign frame_bad = fstart & (vcnt_q != VT_M1);
  assign in_check  = (state_q != SEARCH);
  assign good_inc  = good_q + 4'd1;

  always_comb begin
    hcnt_d = hcnt_q;
    if (h_edge)
      hcnt_d = '0;
    else if (hcnt_q != 10'h3FF)
      hcnt_d = hcnt_q + 10'd1;
  end

  always_comb begin
    vcnt_d = vcnt_q;
    if (fstart)
      vcnt_d = '0;
    else if (h_edge && vcnt_q != 10'h3FF)
      vcnt_d = vcnt_q + 10'd1;
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      SEARCH: begin
        if (fstart) begin
          state_d = CHECK;
          good_d  = '0;
        end
      end
      CHECK: begin
        if (line_bad) begin
          state_d = SEARCH;
        end else if (fstart) begin
          if (frame_bad) begin
            state_d = SEARCH;
          end else begin
            good_d = good_inc;
            if (good_inc == LOCK_N) state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (line_bad || frame_bad) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
  end

  assign frame_count_d = (fstart && state_q == LOCKED) ? frame_count_q + 8'd1 : frame_count_q;

  // Pixel coordinates use the counter values that belong to the sample now in s.
  assign h_in = ({1'b0, hcnt_d} >= H_LO) && ({1'b0, hcnt_d} < H_HI);
  assign v_in = ({1'b0, vcnt_d} >= V_LO) && ({1'b0, vcnt_d} < V_HI);

  always_comb begin
    pix_valid_d = (state_q == LOCKED) && h_in && v_in;
    x_d         = '0;
    y_d         = '0;
    rgb_d       = '0;
    if (pix_valid_d) begin
      x_d   = hcnt_d - H_OFF10;
      y_d   = vcnt_d - V_OFF10;
      rgb_d = {s_q[0], s_q[4], s_q[1], s_q[5], s_q[2], s_q[6]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q           <= '0;
      s_vld_q       <= 1'b0;
      hs_d_q        <= 1'b0;
      v_prev_q      <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      state_q       <= SEARCH;
      good_q        <= '0;
      frame_start_q <= 1'b0;
      err_line_q    <= 1'b0;
      err_frame_q   <= 1'b0;
      frame_count_q <= '0;
      pix_valid_q   <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      rgb_q         <= '0;
    end else begin
      s_q           <= vga_in;
      s_vld_q       <= 1'b1;
      hs_d_q        <= hs;
      v_prev_q      <= v_prev_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      state_q       <= state_d;
      good_q        <= good_d;
      frame_start_q <= fstart;
      err_line_q    <= line_bad & in_check;
      err_frame_q   <= frame_bad & in_check;
      frame_count_q <= frame_count_d;
      pix_valid_q   <= pix_valid_d;
      x_q           <= x_d;
      y_q           <= y_d;
      rgb_q         <= rgb_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign pix_valid   = pix_valid_q;
  assign x           = x_q;
  assign y           = y_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
  assign err_line    = err_line_q;
  assign err_frame   = err_frame_q;

endmodule
